// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet width, packet field positions, VC index type.
// Packets use ascending bit order [0:PKT_W-1]; bit 0 carries the VC.
package noc_pkg;

  localparam int unsigned PKT_W    = 64;
  localparam int unsigned CNT_W    = 16;

  localparam int unsigned VC_BIT   = 0;
  localparam int unsigned DIR_BIT  = 1;
  localparam int unsigned HOP_MSB  = 8;
  localparam int unsigned HOP_LSB  = 15;
  localparam int unsigned DATA_MSB = 32;

  typedef logic              vc_idx_t;
  typedef logic [0:PKT_W-1]  pkt_t;

  // Virtual channel a packet claims to travel on.
  function automatic vc_idx_t pkt_vc(pkt_t pkt);
    return pkt[VC_BIT];
  endfunction

endpackage

// File: rtl/router_nic_port_if.sv
// NIC-facing and fabric-facing handshake bundle of the router local port.
//   master : environment side (NIC and fabric drive strobes/data/readies)
//   slave  : router_nic_port side
interface router_nic_port_if;
  import noc_pkg::*;

  // NIC -> port
  logic net_so;
  pkt_t net_do;
  logic net_ro;
  // port -> NIC
  logic net_si;
  pkt_t net_di;
  logic net_ri;
  // port -> fabric
  logic fab_out_valid;
  pkt_t fab_out_data;
  logic fab_out_ready;
  // fabric -> port
  logic fab_in_valid;
  pkt_t fab_in_data;
  logic fab_in_ready;

  modport master (
    output net_so, net_do, net_ri, fab_out_ready, fab_in_valid, fab_in_data,
    input  net_ro, net_si, net_di, fab_out_valid, fab_out_data, fab_in_ready
  );

  modport slave (
    input  net_so, net_do, net_ri, fab_out_ready, fab_in_valid, fab_in_data,
    output net_ro, net_si, net_di, fab_out_valid, fab_out_data, fab_in_ready
  );

endinterface

// File: rtl/router_nic_port_vc_slot.sv
// vc_slot: one-entry packet buffer with full flag.
//   clk, reset (async, active-low)
//   load   : capture d and set full
//   unload : clear full (data is left in place; consumers gate it with full)
//   q, full: stored packet and occupancy
module vc_slot
  import noc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic unload,
  input  pkt_t d,
  output pkt_t q,
  output logic full
);

  // Occupancy; load and unload never coincide because of the VC phasing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  // Payload register, held unchanged until the next load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/router_nic_port.sv
// router_nic_port: router-side termination of the NIC network interface.
// Buffers NIC injections toward the fabric and fabric ejections toward the NIC
// in two one-entry VC slots per direction. A free-running polarity bit p
// steers the NIC side to VC ~p and the fabric side to VC p each cycle, so no
// slot is written and read in the same cycle.
//   clk, reset (async, active-low)
//   bus          : NIC (net_*) and fabric (fab_*) handshakes, slave modport
//   net_polarity : current phase p, fed to the NIC
//   vc_err       : sticky flag, a captured packet's VC bit disagreed with its slot
//   inj_cnt      : packets accepted from the NIC (wraps)
//   ej_cnt       : packets delivered to the NIC (wraps)
module router_nic_port
  import noc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  router_nic_port_if.slave   bus,
  output logic               net_polarity,
  output logic               vc_err,
  output logic [CNT_W-1:0]   inj_cnt,
  output logic [CNT_W-1:0]   ej_cnt
);

  logic    p;
  vc_idx_t nic_vc;
  vc_idx_t fab_vc;

  logic [1:0] inj_full, ej_full;
  logic [1:0] inj_load, inj_unload, ej_load, ej_unload;
  pkt_t       inj_q [2];
  pkt_t       ej_q  [2];

  logic inj_take;   // NIC packet accepted this cycle
  logic ej_give;    // packet delivered to NIC this cycle
  logic fab_take;   // fabric packet accepted this cycle
  logic fab_give;   // packet handed to fabric this cycle
  logic vc_bad;

  assign nic_vc       = ~p;
  assign fab_vc       = p;
  assign net_polarity = p;

  // Handshake outputs depend only on registered state, p and net_ri.
  assign bus.net_ro        = ~inj_full[nic_vc];
  assign bus.net_si        = ej_full[nic_vc] & bus.net_ri;
  assign bus.net_di        = bus.net_si ? ej_q[nic_vc] : '0;
  assign bus.fab_out_valid = inj_full[fab_vc];
  assign bus.fab_out_data  = bus.fab_out_valid ? inj_q[fab_vc] : '0;
  assign bus.fab_in_ready  = ~ej_full[fab_vc];

  assign inj_take = bus.net_so & bus.net_ro;
  assign ej_give  = bus.net_si;
  assign fab_take = bus.fab_in_valid & bus.fab_in_ready;
  assign fab_give = bus.fab_out_valid & bus.fab_out_ready;

  // Route the four strobes to the slot of the VC active on each side.
  always_comb begin
    inj_load           = 2'b00;
    inj_unload         = 2'b00;
    ej_load            = 2'b00;
    ej_unload          = 2'b00;
    inj_load[nic_vc]   = inj_take;
    ej_unload[nic_vc]  = ej_give;
    inj_unload[fab_vc] = fab_give;
    ej_load[fab_vc]    = fab_take;
  end

  // Captured packet whose VC bit disagrees with the slot it lands in.
  assign vc_bad = (inj_take & (pkt_vc(bus.net_do) != nic_vc)) |
                  (fab_take & (pkt_vc(bus.fab_in_data) != fab_vc));

  for (genvar i = 0; i < 2; i++) begin : g_vc
    vc_slot u_inj (
      .clk    (clk),
      .reset  (reset),
      .load   (inj_load[i]),
      .unload (inj_unload[i]),
      .d      (bus.net_do),
      .q      (inj_q[i]),
      .full   (inj_full[i])
    );

    vc_slot u_ej (
      .clk    (clk),
      .reset  (reset),
      .load   (ej_load[i]),
      .unload (ej_unload[i]),
      .d      (bus.fab_in_data),
      .q      (ej_q[i]),
      .full   (ej_full[i])
    );
  end

  // Phase bit, sticky error flag and packet counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p       <= 1'b0;
      vc_err  <= 1'b0;
      inj_cnt <= '0;
      ej_cnt  <= '0;
    end else begin
      p <= ~p;
      if (vc_bad)   vc_err  <= 1'b1;
      if (inj_take) inj_cnt <= inj_cnt + CNT_W'(1);
      if (ej_give)  ej_cnt  <= ej_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_router_nic_port.sv
// Directed bench for router_nic_port: a vector table for the basic
// inject/eject flow, then hand sequences for stalls, VC errors and reset.
module tb_router_nic_port;
  import noc_pkg::*;

  logic        clk;
  logic        reset;
  logic        net_polarity;
  logic        vc_err;
  logic [15:0] inj_cnt;
  logic [15:0] ej_cnt;

  router_nic_port_if bus_if ();

  router_nic_port dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if.slave),
    .net_polarity (net_polarity),
    .vc_err       (vc_err),
    .inj_cnt      (inj_cnt),
    .ej_cnt       (ej_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic exp_p  = 1'b0;

  typedef struct {
    logic        so;
    pkt_t        dd;
    logic        ri;
    logic        fo_rdy;
    logic        fiv;
    pkt_t        fid;
    logic        e_ro;
    logic        e_si;
    pkt_t        e_di;
    logic        e_fov;
    pkt_t        e_fod;
    logic        e_fir;
    logic [15:0] e_inj;
    logic [15:0] e_ej;
    logic        e_err;
  } vec_t;

  function automatic pkt_t mk(logic vc, logic dir, logic [7:0] hop, logic [31:0] pl);
    pkt_t r;
    r                    = '0;
    r[VC_BIT]            = vc;
    r[DIR_BIT]           = dir;
    r[HOP_MSB:HOP_LSB]   = hop;
    r[DATA_MSB:PKT_W-1]  = pl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic ro, input logic si, input pkt_t di,
                           input logic fov, input pkt_t fod, input logic fir,
                           input logic [15:0] ninj, input logic [15:0] nej, input logic err);
    chk({tag, ".pol"},  64'(net_polarity),         64'(exp_p));
    chk({tag, ".ro"},   64'(bus_if.net_ro),        64'(ro));
    chk({tag, ".si"},   64'(bus_if.net_si),        64'(si));
    chk({tag, ".di"},   bus_if.net_di,             di);
    chk({tag, ".fov"},  64'(bus_if.fab_out_valid), 64'(fov));
    chk({tag, ".fod"},  bus_if.fab_out_data,       fod);
    chk({tag, ".fir"},  64'(bus_if.fab_in_ready),  64'(fir));
    chk({tag, ".inj"},  64'(inj_cnt),              64'(ninj));
    chk({tag, ".ej"},   64'(ej_cnt),               64'(nej));
    chk({tag, ".err"},  64'(vc_err),               64'(err));
  endtask

  task automatic drive(input logic so, input pkt_t dd, input logic ri,
                       input logic fo_rdy, input logic fiv, input pkt_t fid);
    bus_if.net_so        = so;
    bus_if.net_do        = dd;
    bus_if.net_ri        = ri;
    bus_if.fab_out_ready = fo_rdy;
    bus_if.fab_in_valid  = fiv;
    bus_if.fab_in_data   = fid;
  endtask

  // One cycle: apply inputs, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input vec_t v);
    drive(v.so, v.dd, v.ri, v.fo_rdy, v.fiv, v.fid);
    #2;
    check_all(tag, v.e_ro, v.e_si, v.e_di, v.e_fov, v.e_fod, v.e_fir, v.e_inj, v.e_ej, v.e_err);
    @(posedge clk);
    #1;
    exp_p = ~exp_p;
  endtask

  function automatic vec_t mv(logic so, pkt_t dd, logic ri, logic fo_rdy, logic fiv, pkt_t fid,
                              logic ro, logic si, pkt_t di, logic fov, pkt_t fod, logic fir,
                              logic [15:0] ninj, logic [15:0] nej, logic err);
    vec_t v;
    v.so = so; v.dd = dd; v.ri = ri; v.fo_rdy = fo_rdy; v.fiv = fiv; v.fid = fid;
    v.e_ro = ro; v.e_si = si; v.e_di = di; v.e_fov = fov; v.e_fod = fod; v.e_fir = fir;
    v.e_inj = ninj; v.e_ej = nej; v.e_err = err;
    return v;
  endfunction

  vec_t tv [11];

  initial begin
    pkt_t n, a, b, c, d, e, f, g, h, x, y, z;
    n = '0;
    a = mk(1'b1, 1'b0, 8'h03, 32'h0000_0001);
    b = mk(1'b0, 1'b1, 8'h5a, 32'h0000_0002);
    c = mk(1'b1, 1'b1, 8'hff, 32'hdead_beef);
    d = mk(1'b0, 1'b0, 8'h81, 32'h1234_5678);
    e = mk(1'b1, 1'b0, 8'h11, 32'h0000_0005);
    f = mk(1'b1, 1'b1, 8'h22, 32'h0000_0006);
    g = mk(1'b0, 1'b1, 8'h33, 32'h0000_0007);
    h = mk(1'b0, 1'b0, 8'h44, 32'h0000_0008);
    x = mk(1'b0, 1'b1, 8'h55, 32'h0000_0009);
    y = mk(1'b1, 1'b0, 8'h66, 32'h0000_000a);
    z = mk(1'b0, 1'b1, 8'h77, 32'h0000_000b);

    //          so dd ri fr fv fid | ro si di fov fod fir inj ej err
    tv[0]  = mv(0, n, 0, 0, 0, n,    1, 0, n, 0,  n,  1,  0,  0, 0);
    tv[1]  = mv(0, n, 0, 0, 0, n,    1, 0, n, 0,  n,  1,  0,  0, 0);
    tv[2]  = mv(0, n, 0, 0, 0, n,    1, 0, n, 0,  n,  1,  0,  0, 0);
    tv[3]  = mv(0, n, 0, 0, 0, n,    1, 0, n, 0,  n,  1,  0,  0, 0);
    tv[4]  = mv(1, a, 0, 1, 0, n,    1, 0, n, 0,  n,  1,  0,  0, 0);  // p=0: inject VC1
    tv[5]  = mv(0, n, 0, 1, 0, n,    1, 0, n, 1,  a,  1,  1,  0, 0);  // p=1: to fabric
    tv[6]  = mv(0, n, 1, 0, 1, b,    1, 0, n, 0,  n,  1,  1,  0, 0);  // p=0: eject VC0
    tv[7]  = mv(0, n, 1, 0, 0, n,    1, 1, b, 0,  n,  1,  1,  0, 0);  // p=1: to NIC
    tv[8]  = mv(1, c, 1, 1, 1, d,    1, 0, n, 0,  n,  1,  1,  1, 0);  // both directions
    tv[9]  = mv(0, n, 1, 1, 0, n,    1, 1, d, 1,  c,  1,  2,  1, 0);
    tv[10] = mv(0, n, 0, 0, 0, n,    1, 0, n, 0,  n,  1,  2,  2, 0);

    drive(0, n, 0, 0, 0, n);
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_p = 1'b0;
    check_all("rst0", 1, 0, n, 0, n, 1, 0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) cyc($sformatf("vec%0d", i), tv[i]);

    // Injection stall on VC1 with a second VC1 send that must be dropped.
    cyc("is0", mv(0, n, 0, 0, 0, n, 1, 0, n, 0, n, 1, 2, 2, 0));  // p=1
    cyc("is1", mv(1, e, 0, 0, 0, n, 1, 0, n, 0, n, 1, 2, 2, 0));  // p=0 capture e
    cyc("is2", mv(0, n, 0, 0, 0, n, 1, 0, n, 1, e, 1, 3, 2, 0));
    cyc("is3", mv(1, f, 0, 0, 0, n, 0, 0, n, 0, n, 1, 3, 2, 0));  // ignored
    cyc("is4", mv(0, n, 0, 0, 0, n, 1, 0, n, 1, e, 1, 3, 2, 0));
    cyc("is5", mv(1, f, 0, 0, 0, n, 0, 0, n, 0, n, 1, 3, 2, 0));  // ignored
    cyc("is6", mv(0, n, 0, 1, 0, n, 1, 0, n, 1, e, 1, 3, 2, 0));  // drained
    cyc("is7", mv(0, n, 0, 0, 0, n, 1, 0, n, 0, n, 1, 3, 2, 0));
    cyc("is8", mv(0, n, 0, 1, 0, n, 1, 0, n, 0, n, 1, 3, 2, 0));  // nothing stale

    // Ejection stall on VC0: NIC not ready, second fabric packet dropped.
    cyc("es1", mv(0, n, 0, 0, 1, g, 1, 0, n, 0, n, 1, 3, 2, 0));  // p=0 capture g
    cyc("es2", mv(0, n, 0, 0, 0, n, 1, 0, n, 0, n, 1, 3, 2, 0));
    cyc("es3", mv(0, n, 0, 0, 1, h, 1, 0, n, 0, n, 0, 3, 2, 0));  // ignored
    cyc("es4", mv(0, n, 0, 0, 0, n, 1, 0, n, 0, n, 1, 3, 2, 0));
    cyc("es5", mv(0, n, 0, 0, 0, n, 1, 0, n, 0, n, 0, 3, 2, 0));
    cyc("es6", mv(0, n, 1, 0, 0, n, 1, 1, g, 0, n, 1, 3, 2, 0));  // delivered
    cyc("es7", mv(0, n, 1, 0, 0, n, 1, 0, n, 0, n, 1, 3, 3, 0));
    cyc("es8", mv(0, n, 1, 0, 0, n, 1, 0, n, 0, n, 1, 3, 3, 0));

    // VC0 packet injected into slot 1: flagged, still forwarded, sticky.
    cyc("ve1", mv(1, x, 0, 1, 0, n, 1, 0, n, 0, n, 1, 3, 3, 0));
    cyc("ve2", mv(0, n, 0, 1, 0, n, 1, 0, n, 1, x, 1, 4, 3, 1));
    cyc("ve3", mv(0, n, 0, 1, 0, n, 1, 0, n, 0, n, 1, 4, 3, 1));
    cyc("ve4", mv(0, n, 0, 1, 0, n, 1, 0, n, 0, n, 1, 4, 3, 1));

    // Fill both directions, then reset asynchronously mid-cycle.
    cyc("rf1", mv(1, y, 0, 0, 1, z, 1, 0, n, 0, n, 1, 4, 3, 1));
    cyc("rf2", mv(0, n, 0, 0, 0, n, 1, 0, n, 1, y, 1, 5, 3, 1));
    cyc("rf3", mv(0, n, 0, 0, 0, n, 0, 0, n, 0, n, 0, 5, 3, 1));
    drive(0, n, 1, 1, 0, n);
    #2;
    reset = 1'b0;
    #1;
    exp_p = 1'b0;
    check_all("rsta", 1, 0, n, 0, n, 1, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("rstb", 1, 0, n, 0, n, 1, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc($sformatf("post%0d", i), mv(0, n, 1, 1, 0, n, 1, 0, n, 0, n, 1, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_nic_port.md
# router_nic_port

Router-side local port terminating the NIC network interface: the counterpart of the NIC's net_so/net_ro/net_do and net_si/net_ri/net_di/net_polarity pins. It buffers packets the NIC injects and forwards them into the router fabric. It also buffers packets the fabric ejects and delivers them to the NIC. Two virtual channels (VC0/VC1) are time-multiplexed by a self-generated polarity bit, so each one-entry VC slot is never written and read in the same cycle.

## Interface
- PKT_W, 64, packet width; bit order [0:PKT_W-1]
- CNT_W, 16, width of the packet counters
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- net_polarity  output  1  VC phase bit p; drives the NIC polarity input
- net_so  input  1  NIC send strobe (NIC→port)
- net_do  input  PKT_W  NIC injected packet
- net_ro  output  1  port ready to accept from NIC
- net_si  output  1  port send strobe (port→NIC)
- net_di  output  PKT_W  ejected packet to NIC
- net_ri  input  1  NIC ready to accept
- fab_out_valid  output  1  injected packet available to fabric
- fab_out_data  output  PKT_W  injected packet
- fab_out_ready  input  1  fabric accepts injected packet
- fab_in_valid  input  1  fabric ejecting a packet
- fab_in_data  input  PKT_W  ejected packet
- fab_in_ready  output  1  port accepts ejected packet
- vc_err  output  1  sticky VC-mismatch flag
- inj_cnt  output  CNT_W  packets accepted from NIC
- ej_cnt  output  CNT_W  packets delivered to NIC

## Operation
- Packet fields: [0] VC, [1] DIR, [8:15] hop count, [32:63] payload. The port never modifies the packet; forwarding is bit-exact.
- Polarity p: 0 out of reset, toggles every clock.
- State: inj_slot[0..1] and ej_slot[0..1]. Each slot holds one packet plus a full bit.
- NIC side, cycle with polarity p, uses VC ~p:
  - net_ro = ~inj_full[~p].
  - On net_so & net_ro: capture net_do into inj_slot[~p], set full, increment inj_cnt.
  - net_si = ej_full[~p] & net_ri; net_di = ej_slot[~p] when net_si, else 0.
  - On net_si: clear ej_full[~p], increment ej_cnt.
- Fabric side, same cycle, uses VC p:
  - fab_out_valid = inj_full[p]; fab_out_data = inj_slot[p] when valid, else 0. On valid & ready, clear inj_full[p].
  - fab_in_ready = ~ej_full[p]. On fab_in_valid & fab_in_ready, capture into ej_slot[p] and set full.
- net_so while net_ro = 0 is ignored: no capture, no count. fab_in_valid while not ready is ignored the same way.
- VC check: if a captured packet's bit [0] differs from the slot index, set vc_err. The packet is still stored and forwarded. vc_err clears only on reset.
- Counters wrap modulo 2^CNT_W.

## Timing
- Reset (asynchronous, any time): net_polarity=0, all full bits=0, net_ro=1, net_si=0, net_di=0, fab_out_valid=0, fab_out_data=0, fab_in_ready=1, vc_err=0, counters=0. Buffered packets are dropped.
- Injection latency: packet captured at edge k is presented on fab_out at the cycle after edge k, because polarity has flipped. Minimum 1 cycle NIC→fabric; ejection is symmetric.
- net_ro, fab_in_ready, net_si and fab_out_valid are combinational from registered state, p and net_ri only. There is no path from net_so or fab_in_valid.
- Simultaneous fill and drain of one slot is impossible by construction, so there is no bypass and no pass-through.
- A full slot blocks its VC until drained. The other VC is unaffected, and each VC phase recurs every 2 cycles.
- Under sustained stall, a slot holds its data unchanged indefinitely.

## Structure
- Shared package `noc_pkg`:
  - PKT_W;
  - field positions (VC_BIT=0, DIR_BIT=1, HOP_MSB=8, HOP_LSB=15, DATA_MSB=32);
  - a VC index type.
- Sub-module `vc_slot`: one-entry register, full flag, load/unload strobes, asynchronous active-low reset. Instantiated four times.
- Top level contains the polarity flop, steering muxes, VC check, and counters.

## Test plan
- Reset release, idle 4 cycles: net_polarity toggles 0,1,0,1; net_ro=1; fab_in_ready=1; no strobes; counters 0.
- NIC sends packet VC1 payload 0x1 while p=0; fab_out_ready=1: fab_out shows the packet with identical bits the next cycle (p=1); inj_cnt=1; vc_err=0.
- Same packet with fab_out_ready=0 for 3 cycles: net_ro=0 on VC1 phases, still 1 on VC0 phases; a second VC1 send is ignored; exactly one packet appears after ready rises.
- Fabric ejects VC0 payload 0x2 at p=0 with net_ri=1: net_si pulses with net_di = packet at the next p=1 cycle; ej_cnt=1. With net_ri=0 for 3 cycles, the packet is held until net_ri rises.
- NIC injects VC0 packet while p=0 (slot 1): vc_err sets, packet still forwarded, vc_err stays 1 until reset.
- Reset asserted with both directions full: all outputs return to reset values immediately; after release, no stale packet appears.
